mem_initiator: RTL and testbench
================================

Name: mem_initiator

Overview:
- Master-side driver for the team's single-port memory slave interface (valid / wr_rd / addr / wdata in; rdata / ready out).
- Accepts burst commands: start address and beat count, write or read.
- Issues one memory access per beat and waits for the slave's registered ready.
- Streams write data in and read data out with valid/ready handshakes; sits between DMA/test-sequencer logic and the memory.

Parameters:
- WIDTH, 8, data width; must match the memory.
- DEPTH, 256, memory words; addresses wrap modulo DEPTH.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- MAX_LEN, 16, maximum beats per burst.
- LEN_WIDTH, $clog2(MAX_LEN), cmd_len width; cmd_len = beats-1.
- TIMEOUT, 15, wait cycles allowed for mem_ready before abort.

Ports:
- clk  in  1  clock
- res  in  1  reset; asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high
- cmd_wr  in  1  1=write burst, 0=read burst
- cmd_addr  in  ADDR_WIDTH  start address
- cmd_len  in  LEN_WIDTH  beats minus one
- wr_valid  in  1  write data offered
- wr_data  in  WIDTH  write beat data
- wr_ready  out  1  write beat taken when both high
- rd_valid  out  1  read beat presented
- rd_data  out  WIDTH  read beat data
- rd_ready  in  1  consumer takes read beat
- mem_valid  out  1  to memory valid
- mem_wr_rd  out  1  to memory wr_rd
- mem_addr  out  ADDR_WIDTH  to memory addr
- mem_wdata  out  WIDTH  to memory wdata
- mem_rdata  in  WIDTH  from memory rdata
- mem_ready  in  1  from memory ready
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst end
- err  out  1  one-cycle pulse with done when aborted by timeout

Behaviour:
- Reset (async, any state, mid-burst included): state IDLE. All outputs 0: cmd_ready, wr_ready, rd_valid, rd_data, mem_valid, mem_wr_rd, mem_addr, mem_wdata, busy, done, err. Beat and address counters 0. Burst is discarded.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch wr, addr, and beats_left=cmd_len; busy=1; cmd_ready=0.
  - Go to FETCH if write, else ISSUE.
- FETCH (write only):
  - wr_ready=1.
  - On wr_valid: latch wr_data into mem_wdata; go to ISSUE.
- ISSUE:
  - mem_valid=1 for exactly one cycle, with mem_wr_rd/mem_addr/mem_wdata stable.
  - Next state WAIT.
  - mem_valid is never held two consecutive cycles, because the slave repeats the access while valid stays high.
- WAIT:
  - mem_valid=0; timeout counter increments each cycle.
  - On mem_ready=1: read bursts capture mem_rdata into rd_data and go to PUSH; write bursts go to NEXT.
  - If counter reaches TIMEOUT with no ready: go to DONE with err flagged.
  - Nominal slave latency is ready one cycle after valid, so minimum beat cost is 2 cycles (write 3 incl. FETCH with wr_valid already high).
- PUSH: rd_valid=1 and rd_data held stable until rd_ready; then go to NEXT. Backpressure is unbounded, with no timeout.
- NEXT:
  - If beats_left==0, go to DONE.
  - Otherwise beats_left-1, mem_addr+1 wrapping DEPTH-1 to 0, then FETCH (write) or ISSUE (read).
- DONE: done=1 (and err=1 if aborted) for one cycle; busy=0; go to IDLE.
- cmd_valid is ignored while busy. Stray mem_ready outside WAIT is ignored.
- mem_rdata is sampled only in the WAIT cycle where mem_ready=1.

Optional Feature:
- Macro MEM_INIT_STATS_EN.
- Defined:
  - Adds outputs stat_beats (32-bit) and stat_errs (16-bit), both saturating.
  - stat_beats increments on each completed beat (mem_ready seen in WAIT).
  - stat_errs increments on each timeout abort.
  - Both are cleared by res.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mem_if_pkg holds:
  - state enum typedef (IDLE, FETCH, ISSUE, WAIT, PUSH, NEXT, DONE);
  - default WIDTH/DEPTH/TIMEOUT localparams;
  - constant WR=1'b1, RD=1'b0 for mem_wr_rd.
- One sub-module mem_init_timer: loadable down-counter with clear, enable and expired flag; async active-high reset.

Test Plan:
- Single write: cmd wr=1 addr=0x10 len=0, wr_data=0xA5 -> one mem_valid pulse, addr 0x10, wdata 0xA5, wr_rd=1; done 4 cycles after acceptance; err=0.
- Read burst: preload 0x20..0x23 = 1,2,3,4; cmd wr=0 addr=0x20 len=3, rd_ready=1 -> rd_data 1,2,3,4 in order; exactly 4 mem_valid pulses; done once.
- Wrap: write burst addr=0xFE len=3 data 9,8,7,6 -> mem_addr 0xFE,0xFF,0x00,0x01; read back matches.
- Backpressure: read len=1, rd_ready low 5 cycles -> rd_valid and rd_data held stable; no new mem_valid until the beat is taken.
- Timeout: slave model never asserts ready -> after 15 wait cycles done=1 and err=1 together; busy drops; next command accepted.
- Async reset: assert res mid-WAIT of a 4-beat burst -> all outputs 0 immediately, no clock edge needed; a new command after release starts cleanly.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared types and constants for the single-port memory slave interface and its initiator.
package mem_if_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_DEPTH   = 256;
  localparam int DEF_MAX_LEN = 16;
  localparam int DEF_TIMEOUT = 15;

  // mem_wr_rd encoding
  localparam logic WR = 1'b1;
  localparam logic RD = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT,
    PUSH,
    NEXT,
    DONE
  } state_t;

endpackage

// File: rtl/mem_init_timer.sv
// Loadable down-counter for the mem_ready wait window; expired is high while the count is zero.
// No flow control of its own: clr beats load, load beats en, and the count stops at zero.
module mem_init_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          res,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          expired
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/mem_initiator.sv
// Burst master for the single-port memory slave: one access per beat, aborts after TIMEOUT wait cycles.
// Write data and read data use valid/ready handshakes; the optional counters are built with MEM_INIT_STATS_EN.
module mem_initiator
  import mem_if_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int MAX_LEN    = DEF_MAX_LEN,
  parameter int LEN_WIDTH  = $clog2(MAX_LEN),
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  wr_ready,
  output logic                  rd_valid,
  output logic [WIDTH-1:0]      rd_data,
  input  logic                  rd_ready,
  output logic                  mem_valid,
  output logic                  mem_wr_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err
`ifdef MEM_INIT_STATS_EN
  ,
  output logic [31:0]           stat_beats,
  output logic [15:0]           stat_errs
`endif
);

  localparam int TCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  state_t                state;
  logic [LEN_WIDTH-1:0]  beats_left;
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic                  tmr_expired;

  assign addr_inc = (mem_addr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : mem_addr + 1'b1;

  // Loaded while ISSUE is on the bus so the first WAIT cycle sees TIMEOUT-1;
  // expiry on the last allowed WAIT cycle still gives mem_ready priority.
  mem_init_timer #(.CW(TCW)) u_timer (
    .clk      (clk),
    .res      (res),
    .clr      (state == IDLE),
    .load     (state == ISSUE),
    .load_val (TCW'(TIMEOUT - 1)),
    .en       (state == WAIT),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state      <= IDLE;
      beats_left <= '0;
      cmd_ready  <= 1'b0;
      wr_ready   <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      mem_valid  <= 1'b0;
      mem_wr_rd  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      // Pulsed outputs: the slave repeats its access for as long as mem_valid stays high.
      done      <= 1'b0;
      err       <= 1'b0;
      mem_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            mem_wr_rd  <= cmd_wr ? WR : RD;
            mem_addr   <= cmd_addr;
            beats_left <= cmd_len;
            if (cmd_wr) begin
              wr_ready <= 1'b1;
              state    <= FETCH;
            end else begin
              mem_valid <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        FETCH: begin
          if (wr_valid) begin
            mem_wdata <= wr_data;
            wr_ready  <= 1'b0;
            mem_valid <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (mem_ready) begin
            if (mem_wr_rd == RD) begin
              rd_data  <= mem_rdata;
              rd_valid <= 1'b1;
              state    <= PUSH;
            end else begin
              state <= NEXT;
            end
          end else if (tmr_expired) begin
            done  <= 1'b1;
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        PUSH: begin
          if (rd_ready) begin
            rd_valid <= 1'b0;
            state    <= NEXT;
          end
        end
        NEXT: begin
          if (beats_left == '0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            beats_left <= beats_left - 1'b1;
            mem_addr   <= addr_inc;
            if (mem_wr_rd == WR) begin
              wr_ready <= 1'b1;
              state    <= FETCH;
            end else begin
              mem_valid <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        DONE: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_INIT_STATS_EN
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      stat_beats <= '0;
      stat_errs  <= '0;
    end else if (state == WAIT) begin
      if (mem_ready && (stat_beats != '1)) begin
        stat_beats <= stat_beats + 1'b1;
      end
      if (!mem_ready && tmr_expired && (stat_errs != '1)) begin
        stat_errs <= stat_errs + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_initiator.sv
// Bench for mem_initiator: directed scenarios then random bursts against a behavioural memory model.
module tb_mem_initiator;
  localparam int W  = 8;
  localparam int D  = 256;
  localparam int AW = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          res;
  logic          cmd_valid, cmd_ready, cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wr_valid, wr_ready;
  logic [W-1:0]  wr_data;
  logic          rd_valid, rd_ready;
  logic [W-1:0]  rd_data;
  logic          mem_valid, mem_wr_rd, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata, mem_rdata;
  logic          busy, done, err;
`ifdef MEM_INIT_STATS_EN
  logic [31:0]   stat_beats;
  logic [15:0]   stat_errs;
`endif

  always #5 clk = ~clk;

  mem_initiator #(.WIDTH(W), .DEPTH(D), .MAX_LEN(16), .TIMEOUT(15)) dut (
    .clk(clk), .res(res),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .mem_valid(mem_valid), .mem_wr_rd(mem_wr_rd), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .done(done), .err(err)
`ifdef MEM_INIT_STATS_EN
    , .stat_beats(stat_beats), .stat_errs(stat_errs)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave: registered ready one cycle after valid; slave_en=0 models a dead slave.
  logic [W-1:0] slave_mem [D];
  logic         slave_en;
  always @(posedge clk or posedge res) begin
    if (res) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_ready <= mem_valid && slave_en;
      if (mem_valid && slave_en) begin
        if (mem_wr_rd) slave_mem[mem_addr] <= mem_wdata;
        else mem_rdata <= slave_mem[mem_addr];
      end
    end
  end

  // Reference contents of memory as the burst semantics say they should be.
  logic [W-1:0] ref_mem [D];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {logic wr; logic [AW-1:0] addr; logic [W-1:0] wdata;} txn_t;
  txn_t         mq[$];
  logic [W-1:0] rq[$];
  int           done_cnt, err_cnt, done_cyc, acc_cyc;
  logic         busy_at_done;
  logic         prev_mv = 1'b0;

  always @(negedge clk) begin
    if (mem_valid) begin
      mq.push_back('{wr: mem_wr_rd, addr: mem_addr, wdata: mem_wdata});
      check("mem_valid_single_cycle", {31'd0, prev_mv}, 32'd0);
    end
    prev_mv = mem_valid;
    if (rd_valid && rd_ready) rq.push_back(rd_data);
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = busy;
      if (err) err_cnt++;
    end
  end

  // Write-data source with optional random stalls; never drops valid once offered.
  logic [W-1:0] wq[$];
  int           wr_stall = 0;
  initial begin
    logic take;
    wr_valid = 1'b0;
    wr_data  = '0;
    forever begin
      @(negedge clk);
      take = wr_valid && wr_ready;
      @(posedge clk);
      #1;
      if (take && wq.size() > 0) wq.delete(0);
      if (wq.size() == 0) wr_valid = 1'b0;
      else if (!wr_valid || take) begin
        if ($urandom_range(0, 99) >= wr_stall) begin
          wr_valid = 1'b1;
          wr_data  = wq[0];
        end else begin
          wr_valid = 1'b0;
        end
      end
    end
  end

  logic rd_rand = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    if (rd_rand) rd_ready = ($urandom_range(0, 99) < 60);
  end

  logic [W-1:0] bdata [16];

  task automatic issue_cmd(input logic wr, input logic [AW-1:0] addr, input int len);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("cmd_ready_before_issue", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_len   = LW'(len);
    @(posedge clk); #1;
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk); #1; n++;
    end
    check("done_within_budget", {31'd0, (done_cnt > 0)}, 32'd1);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic clear_obs();
    mq.delete(); rq.delete(); wq.delete();
    done_cnt = 0; err_cnt = 0;
  endtask

  task automatic run_burst(input logic wr, input logic [AW-1:0] addr, input int len, input string tag);
    logic [AW-1:0] a;
    txn_t t;
    clear_obs();
    if (wr) for (int i = 0; i <= len; i++) wq.push_back(bdata[i]);
    issue_cmd(wr, addr, len);
    wait_done(1000);
    check({tag, "_beats"}, mq.size(), len + 1);
    for (int i = 0; i <= len; i++) begin
      a = AW'((int'(addr) + i) % D);
      if (i < mq.size()) begin
        t = mq[i];
        check($sformatf("%s_addr%0d", tag, i), t.addr, a);
        check($sformatf("%s_wrrd%0d", tag, i), {31'd0, t.wr}, {31'd0, wr});
        if (wr) check($sformatf("%s_wdata%0d", tag, i), t.wdata, bdata[i]);
      end
      if (wr) ref_mem[a] = bdata[i];
      else if (i < rq.size()) check($sformatf("%s_rdata%0d", tag, i), rq[i], ref_mem[a]);
    end
    if (!wr) check({tag, "_rd_beats"}, rq.size(), len + 1);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_err_cnt"}, err_cnt, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {24'd0, cmd_ready, wr_ready, rd_valid, mem_valid, mem_wr_rd, busy, done, err}, 32'd0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  initial begin
    logic [W-1:0] held;
    int n;
    res = 1'b1;
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
    rd_ready = 1'b1; slave_en = 1'b1;
    for (int i = 0; i < D; i++) begin
      slave_mem[i] = W'($urandom);
      ref_mem[i]   = slave_mem[i];
    end
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    res = 1'b0;
    check("cmd_ready_right_after_reset", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk); #1;
    check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);

    // Single write with data already waiting
    bdata[0] = 8'hA5;
    run_burst(1'b1, 8'h10, 0, "single_wr");
    check("single_wr_latency", done_cyc - acc_cyc, 4);
    check("single_wr_slave", slave_mem[8'h10], 8'hA5);

    // Read burst of preloaded words
    for (int i = 0; i < 4; i++) begin
      slave_mem[8'h20 + i] = W'(i + 1);
      ref_mem[8'h20 + i]   = W'(i + 1);
    end
    run_burst(1'b0, 8'h20, 3, "rd4");
    for (int i = 0; i < 4 && i < rq.size(); i++) check($sformatf("rd4_value%0d", i), rq[i], i + 1);

    // Address wrap across the top of memory, then read back
    bdata[0] = 8'd9; bdata[1] = 8'd8; bdata[2] = 8'd7; bdata[3] = 8'd6;
    run_burst(1'b1, 8'hFE, 3, "wrap_wr");
    run_burst(1'b0, 8'hFE, 3, "wrap_rd");

    // Read backpressure: beat must hold and no new access until taken
    clear_obs();
    rd_ready = 1'b0;
    issue_cmd(1'b0, 8'h20, 1);
    n = 0;
    while (rd_valid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    check("bp_rd_valid_seen", {31'd0, rd_valid}, 32'd1);
    held = rd_data;
    check("bp_first_data", held, ref_mem[8'h20]);
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_rd_valid_held", {31'd0, rd_valid}, 32'd1);
      check("bp_rd_data_held", rd_data, held);
      check("bp_no_new_access", mq.size(), 1);
    end
    rd_ready = 1'b1;
    wait_done(100);
    check("bp_beats", rq.size(), 2);
    if (rq.size() == 2) check("bp_second_data", rq[1], ref_mem[8'h21]);
    check("bp_accesses", mq.size(), 2);

    // Timeout: dead slave
    clear_obs();
    slave_en = 1'b0;
    issue_cmd(1'b0, 8'h30, 3);
    wait_done(100);
    check("to_latency", done_cyc - acc_cyc, 16);
    check("to_err_with_done", err_cnt, 1);
    check("to_done_once", done_cnt, 1);
    check("to_busy_at_done", {31'd0, busy_at_done}, 32'd0);
    check("to_single_access", mq.size(), 1);
    slave_en = 1'b1;
    bdata[0] = 8'h3C;
    run_burst(1'b1, 8'h40, 0, "after_to");

    // Asynchronous reset mid-WAIT
    clear_obs();
    slave_en = 1'b0;
    issue_cmd(1'b0, 8'h50, 3);
    n = 0;
    while (mq.size() == 0 && n < 50) begin @(posedge clk); #1; n++; end
    @(negedge clk);
    check("arst_busy_before", {31'd0, busy}, 32'd1);
    #2 res = 1'b1;
    #1 check_all_zero("arst");
    @(posedge clk); #1;
    res = 1'b0;
    slave_en = 1'b1;
    run_burst(1'b0, 8'h20, 3, "after_arst");

    // Random bursts
    rd_rand  = 1'b1;
    wr_stall = 30;
    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < 16; i++) bdata[i] = W'($urandom);
      run_burst(1'($urandom_range(0, 1)), AW'($urandom), int'($urandom_range(0, 15)), $sformatf("rnd%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "global timeout");
  end

endmodule
